// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and entry layout, also used by the execute stages.
package rob_pkg;

   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);
   localparam int unsigned CNT_W     = TAG_W + 1;
   localparam int unsigned ARCH_W    = 5;
   localparam int unsigned PHY_W     = 6;
   localparam int unsigned DATA_W    = 32;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [ARCH_W-1:0] rdst;
      logic [PHY_W-1:0]  phydst;
      logic [PHY_W-1:0]  old_phydst;
      logic [DATA_W-1:0] result;
   } rob_entry_t;

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch, writeback, commit and free-list signals between the pipeline and the ROB.
interface rob_commit_if
   import rob_pkg::*;
   ;

   logic              flush;

   logic              disp_valid;
   logic [ARCH_W-1:0] disp_rdst;
   logic [PHY_W-1:0]  disp_phydst;
   logic [PHY_W-1:0]  disp_old_phydst;
   logic              disp_ready;
   logic [TAG_W-1:0]  disp_tag;

   logic              wb0_valid;
   logic [TAG_W-1:0]  wb0_tag;
   logic [DATA_W-1:0] wb0_result;
   logic              wb1_valid;
   logic [TAG_W-1:0]  wb1_tag;
   logic [DATA_W-1:0] wb1_result;

   logic              commit_valid;
   logic [ARCH_W-1:0] commit_rdst;
   logic [PHY_W-1:0]  commit_phydst;
   logic [DATA_W-1:0] commit_result;

   logic              free_valid;
   logic [PHY_W-1:0]  free_phydst;

   logic              rob_empty;
   logic [CNT_W-1:0]  rob_count;

   modport master (
      output flush,
      output disp_valid, disp_rdst, disp_phydst, disp_old_phydst,
      input  disp_ready, disp_tag,
      output wb0_valid, wb0_tag, wb0_result,
      output wb1_valid, wb1_tag, wb1_result,
      input  commit_valid, commit_rdst, commit_phydst, commit_result,
      input  free_valid, free_phydst,
      input  rob_empty, rob_count
   );

   modport slave (
      input  flush,
      input  disp_valid, disp_rdst, disp_phydst, disp_old_phydst,
      output disp_ready, disp_tag,
      input  wb0_valid, wb0_tag, wb0_result,
      input  wb1_valid, wb1_tag, wb1_result,
      output commit_valid, commit_rdst, commit_phydst, commit_result,
      output free_valid, free_phydst,
      output rob_empty, rob_count
   );

endinterface

// File: rtl/rob_ptr_ctr.sv
// Wrapping circular-buffer pointer with increment enable and synchronous clear.
module rob_ptr_ctr #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] ptr_o
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   // Width equals log2(depth), so natural overflow provides the wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit.sv
// In-order reorder buffer: tags dispatches, absorbs out-of-order writebacks,
// retires head entries in program order and releases the previous mapping.
module rob_commit
   import rob_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   rob_commit_if.slave  rob_if
);

   rob_entry_t        entries_q [ROB_DEPTH];
   rob_entry_t        entries_d [ROB_DEPTH];

   logic [TAG_W-1:0]  head_ptr;
   logic [TAG_W-1:0]  tail_ptr;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;

   logic              commit_valid_q, commit_valid_d;
   logic [ARCH_W-1:0] commit_rdst_q,  commit_rdst_d;
   logic [PHY_W-1:0]  commit_phydst_q, commit_phydst_d;
   logic [DATA_W-1:0] commit_result_q, commit_result_d;
   logic [PHY_W-1:0]  free_phydst_q,  free_phydst_d;

   logic              clr_c;
   logic              disp_ready_c;
   logic              disp_fire_c;
   logic              commit_fire_c;
   logic              head_inc_c;

   assign clr_c         = rst | rob_if.flush;
   assign disp_ready_c  = (count_q != CNT_W'(ROB_DEPTH));
   assign disp_fire_c   = rob_if.disp_valid & disp_ready_c & ~rob_if.flush;
   assign commit_fire_c = entries_q[head_ptr].valid & entries_q[head_ptr].done;
   assign head_inc_c    = commit_fire_c & ~rob_if.flush;

   rob_ptr_ctr #(.W(TAG_W)) u_head (
      .clk   (clk),
      .rst   (rst),
      .clr_i (rob_if.flush),
      .inc_i (head_inc_c),
      .ptr_o (head_ptr)
   );

   rob_ptr_ctr #(.W(TAG_W)) u_tail (
      .clk   (clk),
      .rst   (rst),
      .clr_i (rob_if.flush),
      .inc_i (disp_fire_c),
      .ptr_o (tail_ptr)
   );

   // Entry array update: port 1 first so port 0 overrides on a tag collision.
   always_comb begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
         entries_d[i] = entries_q[i];
      end
      if (clr_c) begin
         for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            entries_d[i] = '0;
         end
      end else begin
         if (rob_if.wb1_valid && entries_q[rob_if.wb1_tag].valid) begin
            entries_d[rob_if.wb1_tag].done   = 1'b1;
            entries_d[rob_if.wb1_tag].result = rob_if.wb1_result;
         end
         if (rob_if.wb0_valid && entries_q[rob_if.wb0_tag].valid) begin
            entries_d[rob_if.wb0_tag].done   = 1'b1;
            entries_d[rob_if.wb0_tag].result = rob_if.wb0_result;
         end
         if (commit_fire_c) begin
            entries_d[head_ptr] = '0;
         end
         if (disp_fire_c) begin
            entries_d[tail_ptr].valid      = 1'b1;
            entries_d[tail_ptr].done       = 1'b0;
            entries_d[tail_ptr].rdst       = rob_if.disp_rdst;
            entries_d[tail_ptr].phydst     = rob_if.disp_phydst;
            entries_d[tail_ptr].old_phydst = rob_if.disp_old_phydst;
            entries_d[tail_ptr].result     = '0;
         end
      end
   end

   // Occupancy: simultaneous dispatch and commit cancel out.
   always_comb begin
      count_d = count_q;
      if (clr_c) begin
         count_d = '0;
      end else if (disp_fire_c && !commit_fire_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!disp_fire_c && commit_fire_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Retire outputs pulse valid for one cycle; data holds between retires.
   always_comb begin
      commit_valid_d  = 1'b0;
      commit_rdst_d   = commit_rdst_q;
      commit_phydst_d = commit_phydst_q;
      commit_result_d = commit_result_q;
      free_phydst_d   = free_phydst_q;
      if (clr_c) begin
         commit_rdst_d   = '0;
         commit_phydst_d = '0;
         commit_result_d = '0;
         free_phydst_d   = '0;
      end else if (commit_fire_c) begin
         commit_valid_d  = 1'b1;
         commit_rdst_d   = entries_q[head_ptr].rdst;
         commit_phydst_d = entries_q[head_ptr].phydst;
         commit_result_d = entries_q[head_ptr].result;
         free_phydst_d   = entries_q[head_ptr].old_phydst;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
         entries_q[i] <= entries_d[i];
      end
      count_q         <= count_d;
      commit_valid_q  <= commit_valid_d;
      commit_rdst_q   <= commit_rdst_d;
      commit_phydst_q <= commit_phydst_d;
      commit_result_q <= commit_result_d;
      free_phydst_q   <= free_phydst_d;
   end

   assign rob_if.disp_ready    = disp_ready_c;
   assign rob_if.disp_tag      = tail_ptr;
   assign rob_if.commit_valid  = commit_valid_q;
   assign rob_if.commit_rdst   = commit_rdst_q;
   assign rob_if.commit_phydst = commit_phydst_q;
   assign rob_if.commit_result = commit_result_q;
   assign rob_if.free_valid    = commit_valid_q;
   assign rob_if.free_phydst   = free_phydst_q;
   assign rob_if.rob_empty     = (count_q == '0);
   assign rob_if.rob_count     = count_q;

endmodule
